// File: rtl/arbiter_drr.sv
// Deficit round-robin scheduler: one burst resource shared by P_REQUESTER_NUM
// requesters, each credited P_QUANTUM[i] beats per round, grant held for the whole burst.

module arbiter_drr_lane #(
    parameter int P_DEFICIT_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   upd,
    input  logic [P_DEFICIT_W-1:0] d_nxt,
    input  logic                   vis_nxt,
    output logic [P_DEFICIT_W-1:0] deficit,
    output logic                   visited
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deficit <= '0;
            visited <= 1'b0;
        end else if (upd) begin
            deficit <= d_nxt;
            visited <= vis_nxt;
        end
    end
endmodule

module arbiter_drr #(
    parameter int P_REQUESTER_NUM = 4,
    parameter int P_LEN_W         = 8,
    parameter int P_DEFICIT_W     = 10,
    parameter int P_QUANTUM [P_REQUESTER_NUM] = '{8, 4, 4, 2}
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [P_REQUESTER_NUM-1:0]         request,
    input  logic [P_REQUESTER_NUM*P_LEN_W-1:0] req_len,
    output logic [P_REQUESTER_NUM-1:0]         grant_valid,
    input  logic                               grant_ready,
    input  logic                               beat_done,
    output logic                               busy
);
    localparam int PTR_W = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1;
    localparam logic [P_DEFICIT_W-1:0] D_MAX = '1;

    typedef enum logic [1:0] {SCAN, GRANT, XFER} state_t;

    state_t                                      state, state_nxt;
    logic [PTR_W-1:0]                            ptr, ptr_nxt, ptr_inc;
    logic [P_LEN_W-1:0]                          cnt, cnt_nxt;
    logic [P_REQUESTER_NUM-1:0]                  gv_nxt;
    logic [P_REQUESTER_NUM-1:0][P_LEN_W-1:0]     len_arr;
    logic [P_REQUESTER_NUM-1:0][P_DEFICIT_W-1:0] q_tab;
    logic [P_REQUESTER_NUM-1:0][P_DEFICIT_W-1:0] deficit;
    logic [P_REQUESTER_NUM-1:0]                  visited;
    logic [P_REQUESTER_NUM-1:0]                  upd;
    logic [P_DEFICIT_W-1:0]                      d_wr, d_cur, dv, len_ext;
    logic [P_DEFICIT_W:0]                        d_sum;
    logic [P_LEN_W-1:0]                          len_eff;
    logic                                        vis_wr;

    assign len_arr = req_len;

    for (genvar g = 0; g < P_REQUESTER_NUM; g++) begin : g_lane
        assign q_tab[g] = P_DEFICIT_W'(P_QUANTUM[g]);
        arbiter_drr_lane #(.P_DEFICIT_W(P_DEFICIT_W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .upd     (upd[g]),
            .d_nxt   (d_wr),
            .vis_nxt (vis_wr),
            .deficit (deficit[g]),
            .visited (visited[g])
        );
    end

    // A zero-length request is served as a single beat.
    assign len_eff = (len_arr[ptr] == '0) ? P_LEN_W'(1) : len_arr[ptr];
    assign len_ext = P_DEFICIT_W'(len_eff);
    assign ptr_inc = (ptr == PTR_W'(P_REQUESTER_NUM - 1)) ? '0 : ptr + PTR_W'(1);
    assign d_cur   = deficit[ptr];
    assign d_sum   = {1'b0, d_cur} + {1'b0, q_tab[ptr]};
    // Quantum is credited once per visit; a revisit after a burst reuses the remainder.
    assign dv      = visited[ptr] ? d_cur
                   : (d_sum[P_DEFICIT_W] ? D_MAX : d_sum[P_DEFICIT_W-1:0]);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gv_nxt    = grant_valid;
        upd       = '0;
        d_wr      = dv;
        vis_wr    = 1'b0;
        case (state)
            SCAN: begin
                if (|request) begin
                    upd[ptr] = 1'b1;
                    if (request[ptr] && dv >= len_ext) begin
                        d_wr        = dv - len_ext;
                        vis_wr      = 1'b1;
                        gv_nxt      = '0;
                        gv_nxt[ptr] = 1'b1;
                        cnt_nxt     = len_eff;
                        state_nxt   = GRANT;
                    end else begin
                        d_wr    = request[ptr] ? dv : '0;
                        ptr_nxt = ptr_inc;
                    end
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_nxt = XFER;
                end else if (!request[ptr]) begin
                    gv_nxt    = '0;
                    upd[ptr]  = 1'b1;
                    d_wr      = '0;
                    ptr_nxt   = ptr_inc;
                    state_nxt = SCAN;
                end
            end
            XFER: begin
                if (beat_done) begin
                    cnt_nxt = cnt - P_LEN_W'(1);
                    if (cnt == P_LEN_W'(1)) begin
                        gv_nxt    = '0;
                        state_nxt = SCAN;
                    end
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SCAN;
            ptr         <= '0;
            cnt         <= '0;
            grant_valid <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            grant_valid <= gv_nxt;
            busy        <= (state_nxt != SCAN);
        end
    end
endmodule

// File: tb/tb_arbiter_drr.sv
// Self-checking bench for arbiter_drr: directed scenarios plus random traffic,
// every cycle compared against a queue/arithmetic model of the DRR rules.

module tb_arbiter_drr;
    localparam int N    = 4;
    localparam int LW   = 8;
    localparam int DW   = 10;
    localparam int QUANT [N] = '{8, 4, 4, 2};
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  request = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]  grant_valid;
    logic          grant_ready = 1'b0;
    logic          beat_done = 1'b0;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    arbiter_drr #(
        .P_REQUESTER_NUM (N),
        .P_LEN_W         (LW),
        .P_DEFICIT_W     (DW),
        .P_QUANTUM       (QUANT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .req_len     (req_len),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .beat_done   (beat_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: credit balance per requester, whether it already got this
    // round's quantum, whose turn it is, and how many beats remain.
    int           m_credit [N];
    bit           m_paid [N];
    int           m_turn;
    int           m_left;
    int           m_phase;   // 0 scanning, 1 offered, 2 transferring
    logic [N-1:0] exp_gv;
    logic         exp_busy;

    function automatic int eff_len(int i);
        int l;
        l = int'(req_len[i*LW +: LW]);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic void model_step();
        int p, dv;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_credit[i] = 0;
                m_paid[i]   = 0;
            end
            m_turn = 0; m_left = 0; m_phase = 0;
        end else if (m_phase == 0) begin
            if (request != '0) begin
                p  = m_turn;
                dv = m_paid[p] ? m_credit[p]
                   : ((m_credit[p] + QUANT[p] > DMAX) ? DMAX : m_credit[p] + QUANT[p]);
                if (request[p] && dv >= eff_len(p)) begin
                    m_credit[p] = dv - eff_len(p);
                    m_paid[p]   = 1;
                    m_left      = eff_len(p);
                    m_phase     = 1;
                end else begin
                    m_credit[p] = request[p] ? dv : 0;
                    m_paid[p]   = 0;
                    m_turn      = (p + 1) % N;
                end
            end
        end else if (m_phase == 1) begin
            if (grant_ready) m_phase = 2;
            else if (!request[m_turn]) begin
                m_credit[m_turn] = 0;
                m_paid[m_turn]   = 0;
                m_turn  = (m_turn + 1) % N;
                m_phase = 0;
            end
        end else begin
            if (beat_done) begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        end
        exp_gv   = (m_phase != 0) ? N'(1 << m_turn) : '0;
        exp_busy = (m_phase != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_len(int i, int l);
        req_len[i*LW +: LW] = LW'(l);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; request = 4'b1111; grant_ready = 1'b0; beat_done = 1'b0;
        for (int i = 0; i < N; i++) set_len(i, 4);
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (grant_valid !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: gv=%b busy=%b, want gv=0000 busy=0", grant_valid, busy);
            end
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (grant_valid !== 4'b0001 || busy !== 1'b1 || exp_gv !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: gv=%b busy=%b, want gv=0001 busy=1", grant_valid, busy);
        end
    endtask

    task automatic test_fairness();
        int seq [9] = '{0, 0, 1, 2, 0, 0, 1, 2, 3};
        int got [$];
        logic [N-1:0] prev;
        request = 4'b1111; grant_ready = 1'b1; beat_done = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 4);
        do_reset();
        prev = '0;
        for (int c = 0; c < 200 && got.size() < 9; c++) begin
            tick();
            vectors++;
            if (grant_valid !== exp_gv || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL fairness_cycle %0d: gv=%b busy=%b, want gv=%b busy=%b", c, grant_valid, busy, exp_gv, exp_busy);
            end
            if (prev == '0 && grant_valid != '0)
                for (int i = 0; i < N; i++) if (grant_valid[i]) got.push_back(i);
            prev = grant_valid;
        end
        for (int k = 0; k < 9; k++) begin
            vectors++;
            if (k >= got.size()) begin
                miscompares++;
                $display("FAIL fairness_seq[%0d]: no grant observed, want %0d", k, seq[k]);
            end else if (got[k] != seq[k]) begin
                miscompares++;
                $display("FAIL fairness_seq[%0d]: got %0d, want %0d", k, got[k], seq[k]);
            end
        end
    endtask

    task automatic test_deficit_carry();
        int first = 0;
        logic [N-1:0] first_gv = '0;
        request = 4'b1000; grant_ready = 1'b1; beat_done = 1'b1;
        set_len(3, 4);
        do_reset();
        for (int c = 1; c <= 70; c++) begin
            if (c == 25) begin request = 4'b0001; set_len(0, 200); end
            if (c == 45) request = 4'b1000;
            tick();
            vectors++;
            if (grant_valid !== exp_gv || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL deficit_cycle %0d: gv=%b busy=%b, want gv=%b busy=%b", c, grant_valid, busy, exp_gv, exp_busy);
            end
            if (first == 0 && grant_valid != '0) begin first = c; first_gv = grant_valid; end
        end
        vectors++;
        if (first != 8 || first_gv !== 4'b1000) begin
            miscompares++;
            $display("FAIL deficit_second_visit: first grant cycle %0d gv=%b, want cycle 8 gv=1000", first, first_gv);
        end
    endtask

    task automatic test_len0_sat();
        bit saw3 = 0;
        request = 4'b0100; grant_ready = 1'b1; beat_done = 1'b1;
        set_len(2, 0);
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            tick();
            vectors++;
            if (grant_valid !== exp_gv || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL len0_cycle %0d: gv=%b busy=%b, want gv=%b busy=%b", c, grant_valid, busy, exp_gv, exp_busy);
            end
            if (c == 3 && grant_valid !== 4'b0100) begin
                miscompares++;
                $display("FAIL len0_grant: gv=%b, want 0100", grant_valid);
            end
            if (c == 5 && (grant_valid !== 4'b0000 || busy !== 1'b0)) begin
                miscompares++;
                $display("FAIL len0_one_beat: gv=%b busy=%b, want 0000 0", grant_valid, busy);
            end
        end
        request = 4'b1000; set_len(3, 255);
        for (int c = 0; c < 900; c++) begin
            tick();
            vectors++;
            if (grant_valid !== exp_gv || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL len255_cycle %0d: gv=%b busy=%b, want gv=%b busy=%b", c, grant_valid, busy, exp_gv, exp_busy);
            end
            if (grant_valid == 4'b1000) saw3 = 1;
        end
        vectors++;
        if (!saw3) begin
            miscompares++;
            $display("FAIL len255_granted: no grant to requester 3, want one");
        end
    endtask

    task automatic test_abort_stall();
        request = 4'b0010; grant_ready = 1'b0; beat_done = 1'b1;
        set_len(1, 3);
        do_reset();
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (grant_valid !== 4'b0010 || busy !== 1'b1 || exp_gv !== 4'b0010) begin
                miscompares++;
                $display("FAIL stall_hold %0d: gv=%b busy=%b, want gv=0010 busy=1", c, grant_valid, busy);
            end
        end
        request = 4'b0000;
        tick();
        vectors++;
        if (grant_valid !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: gv=%b busy=%b, want gv=0000 busy=0", grant_valid, busy);
        end
        request = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            vectors++;
            if (grant_valid !== exp_gv || (c < 4 && grant_valid !== 4'b0000) || (c == 4 && grant_valid !== 4'b0010)) begin
                miscompares++;
                $display("FAIL abort_ptr_advance %0d: gv=%b, want %b", c, grant_valid, (c == 4) ? 4'b0010 : 4'b0000);
            end
        end
    endtask

    task automatic test_midburst_reset();
        int first = 0;
        request = 4'b1111; grant_ready = 1'b1; beat_done = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 4);
        do_reset();
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (grant_valid !== 4'b0000 || busy !== 1'b0 || exp_gv !== 4'b0000) begin
            miscompares++;
            $display("FAIL midburst_reset: gv=%b busy=%b, want gv=0000 busy=0", grant_valid, busy);
        end
        rst_n = 1'b1; request = 4'b1000;
        for (int c = 1; c <= 10; c++) begin
            tick();
            vectors++;
            if (grant_valid !== exp_gv || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL post_reset_cycle %0d: gv=%b busy=%b, want gv=%b busy=%b", c, grant_valid, busy, exp_gv, exp_busy);
            end
            if (first == 0 && grant_valid != '0) first = c;
        end
        vectors++;
        if (first != 8) begin
            miscompares++;
            $display("FAIL post_reset_deficit: first grant cycle %0d, want 8", first);
        end
    endtask

    task automatic test_random();
        int owner;
        bit hs;
        request = '0; grant_ready = 1'b0; beat_done = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!request[i] && $urandom_range(0, 3) == 0) begin
                    set_len(i, $urandom_range(0, 12));
                    request[i] = 1'b1;
                end
            grant_ready = ($urandom_range(0, 2) != 0);
            beat_done   = ($urandom_range(0, 3) != 0);
            if (m_phase == 1 && !grant_ready && $urandom_range(0, 15) == 0) request[m_turn] = 1'b0;
            hs    = (m_phase == 1 && grant_ready);
            owner = m_turn;
            tick();
            vectors++;
            if (grant_valid !== exp_gv || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL random_cycle %0d: gv=%b busy=%b, want gv=%b busy=%b", c, grant_valid, busy, exp_gv, exp_busy);
            end
            if (hs && $urandom_range(0, 1) == 0) request[owner] = 1'b0;
        end
    endtask

    initial begin
        m_turn = 0; m_left = 0; m_phase = 0; exp_gv = '0; exp_busy = 1'b0;
        for (int i = 0; i < N; i++) begin m_credit[i] = 0; m_paid[i] = 0; end
        test_reset();
        test_fairness();
        test_deficit_carry();
        test_len0_sat();
        test_abort_stall();
        test_midburst_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
